// File: rtl/l2_reqs_retire_pkg.sv
// Shared types and constants for the L2 miss completion tracker.
// Entry layout, response encodings and the saturating ack-counter helper.
package l2_reqs_retire_pkg;

    localparam int N_ENT     = 4;
    localparam int IDX_BITS  = $clog2(N_ENT);
    localparam int ADDR_BITS = 28;
    localparam int WORDS     = 4;
    localparam int WORD_BITS = 64;
    localparam int LINE_BITS = WORDS * WORD_BITS;
    localparam int CNT_BITS  = 5;
    localparam int MAX_N_L2  = 15;

    localparam logic [CNT_BITS-1:0] CNT_MAX_V = 5'b01111;
    localparam logic [CNT_BITS-1:0] CNT_MIN_V = 5'b10000;

    typedef enum logic [1:0] {
        MSG_DATA     = 2'd0,
        MSG_DATA_CNT = 2'd1,
        MSG_INV_ACK  = 2'd2,
        MSG_RSVD     = 2'd3
    } rspMsg_e;

    typedef enum logic [1:0] {
        ENT_IDLE = 2'd0,
        ENT_WAIT = 2'd1,
        ENT_DONE = 2'd2
    } entState_e;

    typedef struct packed {
        entState_e              state;
        logic [ADDR_BITS-1:0]   addr;
        logic [LINE_BITS-1:0]   line;
        logic [WORDS-1:0]       wordGot;
        logic                   dataSeen;
        logic [CNT_BITS-1:0]    ackCnt;
    } entry_t;

    // Signed add clamped to the counter range; MSB of the result flags a clamp.
    function automatic logic [CNT_BITS:0] satAdd(input logic [CNT_BITS-1:0] a,
                                                 input logic [CNT_BITS-1:0] b);
        logic signed [CNT_BITS:0] sum;
        sum = $signed({a[CNT_BITS-1], a}) + $signed({b[CNT_BITS-1], b});
        if (sum > $signed({1'b0, CNT_MAX_V}))
            return {1'b1, CNT_MAX_V};
        else if (sum < $signed({1'b1, CNT_MIN_V}))
            return {1'b1, CNT_MIN_V};
        else
            return {1'b0, sum[CNT_BITS-1:0]};
    endfunction

endpackage

// File: rtl/l2_reqs_retire_pick.sv
// Lowest-index priority encoder, shared by free-entry, response-match and
// completed-entry selection.
module l2_reqs_retire_pick #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    output logic            valid_o,
    output logic [IDXW-1:0] idx_o
);

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IDXW'(i);
        end
    end

endmodule

// File: rtl/l2_reqs_retire.sv
// Completion tracker for outstanding L2 misses: allocate, collect data/acks, retire.
// Optional SPX_WORD_GRAN_EN: honour rsp_mask_i for partial-line DATA responses.
module l2_reqs_retire
    import l2_reqs_retire_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 alloc_valid_i,
    output logic                 alloc_ready_o,
    input  logic [ADDR_BITS-1:0] alloc_addr_i,
    output logic [IDX_BITS-1:0]  alloc_i_o,
    input  logic                 rsp_valid_i,
    output logic                 rsp_ready_o,
    input  logic [1:0]           rsp_msg_i,
    input  logic [ADDR_BITS-1:0] rsp_addr_i,
    input  logic [CNT_BITS-1:0]  rsp_cnt_i,
    input  logic [LINE_BITS-1:0] rsp_line_i,
    input  logic [WORDS-1:0]     rsp_mask_i,
    output logic                 retire_valid_o,
    input  logic                 retire_ready_i,
    output logic [IDX_BITS-1:0]  retire_i_o,
    output logic [ADDR_BITS-1:0] retire_addr_o,
    output logic [LINE_BITS-1:0] retire_line_o,
    output logic                 rsp_err_o
);

    entry_t                entries_q [N_ENT];
    entry_t                entries_d [N_ENT];
    logic                  rspErr_q, rspErr_d;
    logic                  retireValid_q;
    logic [IDX_BITS-1:0]   retireIdx_q;
    logic [ADDR_BITS-1:0]  retireAddr_q;
    logic [LINE_BITS-1:0]  retireLine_q;

    logic [N_ENT-1:0]      idleVec, matchVec, doneAvail;
    logic                  matchValid, doneValid;
    logic [IDX_BITS-1:0]   matchIdx, doneIdx;
    logic                  allocFire, retireFire;
    logic [WORDS-1:0]      effMask;
    logic [CNT_BITS:0]     satRes;
    entry_t                rspEnt;

    assign rsp_ready_o    = 1'b1;
    assign allocFire      = alloc_valid_i && alloc_ready_o;
    assign retireFire     = retireValid_q && retire_ready_i;
    assign retire_valid_o = retireValid_q;
    assign retire_i_o     = retireIdx_q;
    assign retire_addr_o  = retireAddr_q;
    assign retire_line_o  = retireLine_q;
    assign rsp_err_o      = rspErr_q;

`ifdef SPX_WORD_GRAN_EN
    assign effMask = rsp_mask_i;
`else
    assign effMask = rsp_mask_i | {WORDS{1'b1}};
`endif

    // The entry being retired this cycle must not be re-presented.
    always_comb begin
        idleVec   = '0;
        matchVec  = '0;
        doneAvail = '0;
        for (int i = 0; i < N_ENT; i++) begin
            idleVec[i]   = (entries_q[i].state == ENT_IDLE);
            matchVec[i]  = rsp_valid_i && (entries_q[i].state == ENT_WAIT) &&
                           (entries_q[i].addr == rsp_addr_i);
            doneAvail[i] = (entries_q[i].state == ENT_DONE) &&
                           !(retireFire && (retireIdx_q == IDX_BITS'(i)));
        end
    end

    l2_reqs_retire_pick #(.N(N_ENT)) u_idlePick (
        .req_i(idleVec), .valid_o(alloc_ready_o), .idx_o(alloc_i_o));
    l2_reqs_retire_pick #(.N(N_ENT)) u_matchPick (
        .req_i(matchVec), .valid_o(matchValid), .idx_o(matchIdx));
    l2_reqs_retire_pick #(.N(N_ENT)) u_donePick (
        .req_i(doneAvail), .valid_o(doneValid), .idx_o(doneIdx));

    always_comb begin
        entries_d = entries_q;
        rspErr_d  = rspErr_q;
        rspEnt    = entries_q[matchIdx];
        satRes    = '0;

        if (allocFire) begin
            entries_d[alloc_i_o].state    = ENT_WAIT;
            entries_d[alloc_i_o].addr     = alloc_addr_i;
            entries_d[alloc_i_o].wordGot  = '0;
            entries_d[alloc_i_o].dataSeen = 1'b0;
            entries_d[alloc_i_o].ackCnt   = '0;
        end

        if (retireFire) entries_d[retireIdx_q].state = ENT_IDLE;

        if (rsp_valid_i) begin
            if (!matchValid || rsp_msg_i == MSG_RSVD) begin
                rspErr_d = 1'b1;
            end else begin
                if (rsp_msg_i == MSG_DATA || rsp_msg_i == MSG_DATA_CNT) begin
                    for (int w = 0; w < WORDS; w++) begin
                        if (effMask[w])
                            rspEnt.line[w*WORD_BITS +: WORD_BITS] =
                                rsp_line_i[w*WORD_BITS +: WORD_BITS];
                    end
                    rspEnt.wordGot  = rspEnt.wordGot | effMask;
                    rspEnt.dataSeen = &rspEnt.wordGot;
                end
                if (rsp_msg_i == MSG_DATA_CNT)
                    satRes = satAdd(rspEnt.ackCnt, rsp_cnt_i);
                else if (rsp_msg_i == MSG_INV_ACK)
                    satRes = satAdd(rspEnt.ackCnt, {CNT_BITS{1'b1}});
                else
                    satRes = {1'b0, rspEnt.ackCnt};
                rspEnt.ackCnt = satRes[CNT_BITS-1:0];
                if (satRes[CNT_BITS]) rspErr_d = 1'b1;
                if (rspEnt.dataSeen && rspEnt.ackCnt == '0) rspEnt.state = ENT_DONE;
                entries_d[matchIdx] = rspEnt;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_ENT; i++) entries_q[i] <= '0;
            rspErr_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_ENT; i++) entries_q[i] <= entries_d[i];
            rspErr_q <= rspErr_d;
        end
    end

    // Retire output holds until accepted, then loads the next completed entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retireValid_q <= 1'b0;
            retireIdx_q   <= '0;
            retireAddr_q  <= '0;
            retireLine_q  <= '0;
        end else if (!retireValid_q || retire_ready_i) begin
            retireValid_q <= doneValid;
            if (doneValid) begin
                retireIdx_q  <= doneIdx;
                retireAddr_q <= entries_q[doneIdx].addr;
                retireLine_q <= entries_q[doneIdx].line;
            end
        end
    end

endmodule
